// File: rtl/rs_bank.sv
`default_nettype none
// ============================================================================
// Module   : rs_bank
// Brief    : Two-entry reservation station bank with CDB wakeup, dispatch
//            bypass and oldest-ready issue selection.
// Revision : 1.0
// ============================================================================
module rs_bank #(
    parameter logic [2:0] TAG_0 = 3'd5,
    parameter logic [2:0] TAG_1 = 3'd6
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  DISPATCH_RS,
    input  logic [9:0]  DISPATCH_OP,
    input  logic [2:0]  DISPATCH_QJ,
    input  logic [2:0]  DISPATCH_QK,
    input  logic [31:0] DISPATCH_VJ,
    input  logic [31:0] DISPATCH_VK,
    input  logic [31:0] DISPATCH_IMM,
    input  logic        CDB_VALID,
    input  logic [2:0]  CDB_TAG,
    input  logic [31:0] CDB_DATA,
    input  logic        FU_READY,
    output logic        ISSUE_VALID,
    output logic [9:0]  ISSUE_OP,
    output logic [31:0] ISSUE_VJ,
    output logic [31:0] ISSUE_VK,
    output logic [31:0] ISSUE_IMM,
    output logic [2:0]  ISSUE_TAG,
    output logic [1:0]  BUSY
);

    localparam logic [2:0] c_tag_invalid = 3'd0;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    logic             w_cdb_hit;
    logic [2:0]       w_dqj, w_dqk;
    logic [31:0]      w_dvj, w_dvk;
    logic [1:0]       w_ready;
    logic [1:0]       w_disp;
    logic [1:0][9:0]  w_op;
    logic [1:0][31:0] w_vj, w_vk, w_imm;
    logic             w_sel;
    logic             w_fire;
    logic             r_older;   // 1: entry 1 holds the older instruction

    assign w_cdb_hit = CDB_VALID && (CDB_TAG != c_tag_invalid);

    // Operands produced by the broadcast in the dispatch cycle are taken directly.
    assign w_dqj = (w_cdb_hit && DISPATCH_QJ == CDB_TAG) ? c_tag_invalid : DISPATCH_QJ;
    assign w_dqk = (w_cdb_hit && DISPATCH_QK == CDB_TAG) ? c_tag_invalid : DISPATCH_QK;
    assign w_dvj = (w_cdb_hit && DISPATCH_QJ == CDB_TAG) ? CDB_DATA : DISPATCH_VJ;
    assign w_dvk = (w_cdb_hit && DISPATCH_QK == CDB_TAG) ? CDB_DATA : DISPATCH_VK;

    assign w_sel  = (w_ready[0] && w_ready[1]) ? r_older : w_ready[1];
    assign w_fire = ISSUE_VALID && FU_READY;

    genvar k;
    generate
        for (k = 0; k < 2; k++) begin : g_entry
            localparam logic [2:0] c_my_tag = (k == 0) ? TAG_0 : TAG_1;

            state_t      r_state;
            logic [2:0]  r_qj, r_qk;
            logic [31:0] r_vj, r_vk, r_imm;
            logic [9:0]  r_op;
            logic        w_cap_j, w_cap_k;
            logic        w_issue_me;

            assign w_disp[k]  = (DISPATCH_RS == c_my_tag) && (r_state == ST_FREE);
            assign w_cap_j    = w_cdb_hit && (r_state == ST_WAIT) && (r_qj == CDB_TAG);
            assign w_cap_k    = w_cdb_hit && (r_state == ST_WAIT) && (r_qk == CDB_TAG);
            assign w_issue_me = w_fire && (w_sel == k[0]);

            assign w_ready[k] = (r_state == ST_READY);
            assign BUSY[k]    = (r_state != ST_FREE);
            assign w_op[k]    = r_op;
            assign w_vj[k]    = r_vj;
            assign w_vk[k]    = r_vk;
            assign w_imm[k]   = r_imm;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_state <= ST_FREE;
                    r_qj    <= c_tag_invalid;
                    r_qk    <= c_tag_invalid;
                    r_vj    <= '0;
                    r_vk    <= '0;
                    r_imm   <= '0;
                    r_op    <= '0;
                end else if (w_issue_me) begin
                    r_state <= ST_FREE;
                end else if (w_disp[k]) begin
                    r_op    <= DISPATCH_OP;
                    r_imm   <= DISPATCH_IMM;
                    r_qj    <= w_dqj;
                    r_qk    <= w_dqk;
                    r_vj    <= w_dvj;
                    r_vk    <= w_dvk;
                    r_state <= (w_dqj == c_tag_invalid && w_dqk == c_tag_invalid)
                               ? ST_READY : ST_WAIT;
                end else if (r_state == ST_WAIT) begin
                    if (w_cap_j) begin
                        r_vj <= CDB_DATA;
                        r_qj <= c_tag_invalid;
                    end
                    if (w_cap_k) begin
                        r_vk <= CDB_DATA;
                        r_qk <= c_tag_invalid;
                    end
                    if ((w_cap_j || r_qj == c_tag_invalid) &&
                        (w_cap_k || r_qk == c_tag_invalid))
                        r_state <= ST_READY;
                end
            end
        end
    endgenerate

    // The newly dispatched entry is the younger one; at most one dispatch per cycle.
    always_ff @(posedge CLK) begin
        if (RST)
            r_older <= 1'b0;
        else if (w_disp[0])
            r_older <= 1'b1;
        else if (w_disp[1])
            r_older <= 1'b0;
    end

    always_comb begin
        ISSUE_VALID = |w_ready;
        ISSUE_OP    = '0;
        ISSUE_VJ    = '0;
        ISSUE_VK    = '0;
        ISSUE_IMM   = '0;
        ISSUE_TAG   = c_tag_invalid;
        if (ISSUE_VALID) begin
            ISSUE_OP  = w_op[w_sel];
            ISSUE_VJ  = w_vj[w_sel];
            ISSUE_VK  = w_vk[w_sel];
            ISSUE_IMM = w_imm[w_sel];
            ISSUE_TAG = w_sel ? TAG_1 : TAG_0;
        end
    end

endmodule
`default_nettype wire
